sysclk_rst_gen: RTL and testbench

- Parametrised clock-and-reset generator for the CPU subsystem, running on the PLL output clock.
- Produces the divided CPU clock, with a run-time selectable rate that changes without glitches.
- Produces a delayed CPU reset with three causes: power-on/button, software request, watchdog timeout.
- Replaces the fixed-divider, fixed-delay clock/reset logic at top level; all peripherals keep consuming sys_clk and sys_res unchanged.

---
 rtl/sysclk_rst_gen.sv | 175 +++++++++++++++++
 tb/tb_sysclk_rst_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sysclk_rst_gen.sv
// ---------------------------------------------------------------------------
// sysclk_rst_gen
// Clock-and-reset generator for the CPU subsystem. It runs entirely on the
// PLL clock, clk_in, and produces three things:
//   - sys_clk: a divided CPU clock with 50% duty cycle. The rate can be
//     selected at run time, and a rate change never produces a glitch.
//   - sys_clk_rise: a one-cycle strobe that marks each 0->1 edge of sys_clk.
//   - sys_res: a delayed CPU reset. It has three causes: power-on/button,
//     a software request, and a watchdog timeout.
//
// Ports
//   clk_in        in   PLL clock; the only clock in this block
//   b_reset       in   asynchronous active-low reset
//   div_sel[1:0]  in   rate select; half period = BASE << div_sel
//   sw_reset      in   software reset request (level), sampled at sys_clk rise
//   wdt_en        in   watchdog enable, sampled at sys_clk rise
//   wdt_kick      in   watchdog restart, sampled at sys_clk rise
//   sys_clk       out  divided CPU clock
//   sys_clk_rise  out  one clk_in cycle high when sys_clk goes 0->1
//   sys_res       out  active-high CPU/peripheral reset
//   wdt_fired     out  sticky flag: the watchdog has fired since b_reset
//   res_cause     out  cause of the last reset: 00 por/button, 01 sw, 10 wdt
// ---------------------------------------------------------------------------
module sysclk_rst_gen #(
    parameter int unsigned OSC_CLOCK   = 24000000,
    parameter int unsigned CPU_CLOCK   = 3000000,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned RES_DELAY   = 4,
    parameter int unsigned WDT_W       = 16,
    parameter int unsigned WDT_TIMEOUT = 65535
) (
    input  logic       clk_in,
    input  logic       b_reset,
    input  logic [1:0] div_sel,
    input  logic       sw_reset,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    output logic       sys_clk,
    output logic       sys_clk_rise,
    output logic       sys_res,
    output logic       wdt_fired,
    output logic [1:0] res_cause
);

    localparam int unsigned BASE  = OSC_CLOCK / CPU_CLOCK / 2;
    localparam int unsigned DLY_W = (RES_DELAY < 1) ? 1 : $clog2(RES_DELAY + 1);

    localparam logic [DIV_W-1:0] BASE_V   = DIV_W'(BASE);
    localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(RES_DELAY);
    localparam logic [WDT_W-1:0] WDT_TO   = WDT_W'(WDT_TIMEOUT);

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    // The slowest rate, BASE << 3, must still fit in the half-period counter.
    if (BASE < 1 || (BASE * 8) > (2 ** DIV_W)) begin : g_param_err
        $error("sysclk_rst_gen: BASE=%0d out of range for DIV_W=%0d", BASE, DIV_W);
    end

    // State registers.
    logic [DIV_W-1:0] cnt_q,        cnt_d;
    logic [1:0]       active_sel_q, active_sel_d;
    logic             sys_clk_q,    sys_clk_d;
    logic             rise_q,       rise_d;
    logic             sys_res_q,    sys_res_d;
    logic [DLY_W-1:0] dly_q,        dly_d;
    logic [WDT_W-1:0] wdt_cnt_q,    wdt_cnt_d;
    logic             wdt_fired_q,  wdt_fired_d;
    logic [1:0]       res_cause_q,  res_cause_d;

    // Terminal count of the half period. It uses the rate that is currently
    // active, so a rate change cannot cut the current phase short.
    logic [DIV_W-1:0] half_m1;
    logic             toggle;
    logic             rise_now;
    logic             wdt_timeout;

    assign half_m1  = (BASE_V << active_sel_q) - DIV_W'(1);
    assign toggle   = (cnt_q >= half_m1);
    assign rise_now = toggle & ~sys_clk_q;

    // The watchdog only counts while it is enabled and the CPU is out of
    // reset. A kick or a software request sampled on the same rise wins.
    assign wdt_timeout = ~sys_res_q & wdt_en & ~wdt_kick & ~sw_reset &
                         (wdt_cnt_q == WDT_TO);

    // Next-state logic for the divider, the reset sequencer and the watchdog.
    always_comb begin
        cnt_d        = cnt_q;
        active_sel_d = active_sel_q;
        sys_clk_d    = sys_clk_q;
        rise_d       = 1'b0;
        sys_res_d    = sys_res_q;
        dly_d        = dly_q;
        wdt_cnt_d    = wdt_cnt_q;
        wdt_fired_d  = wdt_fired_q;
        res_cause_d  = res_cause_q;

        // Divider. The new rate is taken only at the 1->0 toggle, so every
        // high or low phase runs for a full old-H or a full new-H.
        if (toggle) begin
            cnt_d     = '0;
            sys_clk_d = ~sys_clk_q;
            rise_d    = ~sys_clk_q;
            if (sys_clk_q) begin
                active_sel_d = div_sel;
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        // Reset sequencer and watchdog advance only on sys_clk rising edges.
        if (rise_now) begin
            if (sw_reset) begin
                sys_res_d   = 1'b1;
                dly_d       = DLY_INIT;
                res_cause_d = CAUSE_SW;
                wdt_cnt_d   = '0;
            end else if (wdt_timeout) begin
                sys_res_d   = 1'b1;
                dly_d       = DLY_INIT;
                res_cause_d = CAUSE_WDT;
                wdt_fired_d = 1'b1;
                wdt_cnt_d   = '0;
            end else begin
                if (sys_res_q) begin
                    if (dly_q == '0) begin
                        sys_res_d = 1'b0;
                    end else begin
                        dly_d = dly_q - DLY_W'(1);
                    end
                end

                if (sys_res_q || !wdt_en || wdt_kick) begin
                    wdt_cnt_d = '0;
                end else if (wdt_cnt_q != '1) begin
                    wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
                end
            end
        end
    end

    // State registers, asynchronously reset by b_reset.
    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            cnt_q        <= '0;
            active_sel_q <= 2'b00;
            sys_clk_q    <= 1'b0;
            rise_q       <= 1'b0;
            sys_res_q    <= 1'b1;
            dly_q        <= DLY_INIT;
            wdt_cnt_q    <= '0;
            wdt_fired_q  <= 1'b0;
            res_cause_q  <= CAUSE_POR;
        end else begin
            cnt_q        <= cnt_d;
            active_sel_q <= active_sel_d;
            sys_clk_q    <= sys_clk_d;
            rise_q       <= rise_d;
            sys_res_q    <= sys_res_d;
            dly_q        <= dly_d;
            wdt_cnt_q    <= wdt_cnt_d;
            wdt_fired_q  <= wdt_fired_d;
            res_cause_q  <= res_cause_d;
        end
    end

    assign sys_clk      = sys_clk_q;
    assign sys_clk_rise = rise_q;
    assign sys_res      = sys_res_q;
    assign wdt_fired    = wdt_fired_q;
    assign res_cause    = res_cause_q;

endmodule

// File: tb/tb_sysclk_rst_gen.sv
// ---------------------------------------------------------------------------
// tb_sysclk_rst_gen
// Directed testbench for sysclk_rst_gen. The DUT uses BASE=4 and
// WDT_TIMEOUT=10. Outputs are sampled on the falling edge of clk_in, and
// inputs are driven on that same falling edge.
// ---------------------------------------------------------------------------
module tb_sysclk_rst_gen;

    logic       clk_in = 1'b0;
    logic       b_reset;
    logic [1:0] div_sel;
    logic       sw_reset;
    logic       wdt_en;
    logic       wdt_kick;
    logic       sys_clk;
    logic       sys_clk_rise;
    logic       sys_res;
    logic       wdt_fired;
    logic [1:0] res_cause;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    sysclk_rst_gen #(
        .OSC_CLOCK  (24000000),
        .CPU_CLOCK  (3000000),
        .DIV_W      (8),
        .RES_DELAY  (4),
        .WDT_W      (16),
        .WDT_TIMEOUT(10)
    ) dut (
        .clk_in      (clk_in),
        .b_reset     (b_reset),
        .div_sel     (div_sel),
        .sw_reset    (sw_reset),
        .wdt_en      (wdt_en),
        .wdt_kick    (wdt_kick),
        .sys_clk     (sys_clk),
        .sys_clk_rise(sys_clk_rise),
        .sys_res     (sys_res),
        .wdt_fired   (wdt_fired),
        .res_cause   (res_cause)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    // Advance to the sample point just after the next sys_clk rise (bounded).
    task automatic wait_rise();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            got = sys_clk_rise;
        end
        check("rise_seen", 32'(got), 32'd1);
    endtask

    initial begin
        int res_seen;

        b_reset  = 1'b0;
        div_sel  = 2'b00;
        sw_reset = 1'b0;
        wdt_en   = 1'b0;
        wdt_kick = 1'b0;

        // Reset state
        step();
        step();
        check("rst_sys_clk",   32'(sys_clk),      32'd0);
        check("rst_rise",      32'(sys_clk_rise), 32'd0);
        check("rst_sys_res",   32'(sys_res),      32'd1);
        check("rst_wdt_fired", 32'(wdt_fired),    32'd0);
        check("rst_cause",     32'(res_cause),    32'd0);

        // 1: base rate, period 8, release at the 5th rise (cycle 36)
        b_reset = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            check("t1_sys_clk", 32'(sys_clk),      32'(((cyc / 4) % 2) == 1));
            check("t1_rise",    32'(sys_clk_rise), 32'((cyc % 8) == 4));
            check("t1_sys_res", 32'(sys_res),      32'(cyc < 36));
        end
        check("t1_cause", 32'(res_cause), 32'd0);

        // 2: rate change in the middle of the high phase (high phase is 44..47)
        step_to(45);
        div_sel = 2'd2;
        step_to(47); check("t2_hi_end",  32'(sys_clk),      32'd1);
        step_to(48); check("t2_fall",    32'(sys_clk),      32'd0);
        step_to(63); check("t2_lo_end",  32'(sys_clk),      32'd0);
        step_to(64); check("t2_rise",    32'(sys_clk),      32'd1);
                     check("t2_rise_p",  32'(sys_clk_rise), 32'd1);
        step_to(65); check("t2_rise_w",  32'(sys_clk_rise), 32'd0);
        step_to(79); check("t2_hi2_end", 32'(sys_clk),      32'd1);
        step_to(80); check("t2_fall2",   32'(sys_clk),      32'd0);
        div_sel = 2'd0;

        // 3: software reset held for 3 rises
        wait_rise();
        check("t3_pre_res", 32'(sys_res), 32'd0);
        sw_reset = 1'b1;
        wait_rise();
        check("t3_res_on", 32'(sys_res),   32'd1);
        check("t3_cause",  32'(res_cause), 32'd1);
        wait_rise();
        wait_rise();
        sw_reset = 1'b0;
        for (int r = 1; r <= 4; r++) wait_rise();
        check("t3_hold4", 32'(sys_res), 32'd1);
        wait_rise();
        check("t3_release", 32'(sys_res),   32'd0);
        check("t3_cause2",  32'(res_cause), 32'd1);
        check("t3_nofire",  32'(wdt_fired), 32'd0);

        // 4: watchdog kicked every 8 rises, then left to expire
        wdt_en = 1'b1;
        res_seen = 0;
        for (int r = 1; r <= 1000; r++) begin
            wdt_kick = ((r % 8) == 0);
            wait_rise();
            if (sys_res) res_seen++;
        end
        wdt_kick = 1'b0;
        check("t4_no_reset", 32'(res_seen), 32'd0);
        for (int r = 1; r <= 10; r++) wait_rise();
        check("t4_pre_fire", 32'(sys_res), 32'd0);
        wait_rise();
        check("t4_fire_res",  32'(sys_res),   32'd1);
        check("t4_fired",     32'(wdt_fired), 32'd1);
        check("t4_cause",     32'(res_cause), 32'd2);
        for (int r = 1; r <= 4; r++) wait_rise();
        check("t4_hold4", 32'(sys_res), 32'd1);
        wait_rise();
        check("t4_release", 32'(sys_res), 32'd0);

        // 6: b_reset pulse during the high phase, with wdt_fired=1 and div_sel=3
        wait_rise();
        check("t6_pre_clk", 32'(sys_clk), 32'd1);
        div_sel = 2'd3;
        b_reset = 1'b0;
        #1;
        check("t6_clk",   32'(sys_clk),   32'd0);
        check("t6_res",   32'(sys_res),   32'd1);
        check("t6_fired", 32'(wdt_fired), 32'd0);
        check("t6_cause", 32'(res_cause), 32'd0);
        step();
        step();
        b_reset = 1'b1;
        cyc = 0;
        step_to(4);  check("t6_rise1",   32'(sys_clk_rise), 32'd1);
        step_to(7);  check("t6_hi_end",  32'(sys_clk),      32'd1);
        step_to(8);  check("t6_fall",    32'(sys_clk),      32'd0);
        step_to(39); check("t6_lo32",    32'(sys_clk),      32'd0);
        step_to(40); check("t6_rise2",   32'(sys_clk),      32'd1);
        div_sel = 2'd0;
        wait_rise();
        wait_rise();
        check("t6_hold", 32'(sys_res), 32'd1);
        wait_rise();
        check("t6_release", 32'(sys_res), 32'd0);

        // 5: a kick on the timeout rise, then sw_reset on the timeout rise
        for (int r = 1; r <= 10; r++) wait_rise();
        check("t5_cnt10_nofire", 32'(sys_res), 32'd0);
        wdt_kick = 1'b1;
        wait_rise();
        wdt_kick = 1'b0;
        check("t5_kick_wins", 32'(sys_res),   32'd0);
        check("t5_kick_flag", 32'(wdt_fired), 32'd0);
        for (int r = 1; r <= 10; r++) wait_rise();
        sw_reset = 1'b1;
        wait_rise();
        sw_reset = 1'b0;
        check("t5_sw_res",   32'(sys_res),   32'd1);
        check("t5_sw_cause", 32'(res_cause), 32'd1);
        check("t5_sw_fired", 32'(wdt_fired), 32'd0);
        for (int r = 1; r <= 5; r++) wait_rise();
        check("t5_release", 32'(sys_res), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
